touch_pad_emulator: RTL and testbench

TOUCH_PAD_EMULATOR -- requirements
Module: touch_pad_emulator

---
 rtl/touch_pad_emulator_pkg.sv | 30 +++
 rtl/touch_pad_emulator_bounce_gen.sv | 76 +++++++
 rtl/touch_pad_emulator.sv | 152 +++++++++++++++
 tb/tb_touch_pad_emulator.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/touch_pad_emulator_pkg.sv
// ============================================================================
// Module : touch_pkg
// Brief  : Shared states, parameter defaults and mode encodings for the
//          touch pad emulator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package touch_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      EDGE_UP   = 2'd1,
      HELD      = 2'd2,
      EDGE_DOWN = 2'd3
   } touch_state_e;

   localparam int DEF_BOUNCE_HALF     = 4;
   localparam int DEF_BOUNCE_GLITCHES = 2;
   localparam int DEF_HOLD_W          = 16;

   localparam int BOUNCE_CNT_W = 8;
   localparam int TRANS_CNT_W  = 5;

   localparam logic MODE_MOMENTARY = 1'b0;
   localparam logic MODE_TOGGLE    = 1'b1;

endpackage

`default_nettype wire

// File: rtl/touch_pad_emulator_bounce_gen.sv
// ============================================================================
// Module : touch_bounce_gen
// Brief  : Produces one bouncing edge: 2*BOUNCE_GLITCHES+1 transitions spaced
//          BOUNCE_HALF cycles apart, settling on target_level.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module touch_bounce_gen
   import touch_pkg::*;
#(
   parameter int BOUNCE_HALF     = DEF_BOUNCE_HALF,
   parameter int BOUNCE_GLITCHES = DEF_BOUNCE_GLITCHES
)(
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic start,
   input  logic target_level,
   output logic line,
   output logic finished
);

   localparam logic [BOUNCE_CNT_W-1:0] HALF_M1 = BOUNCE_CNT_W'(BOUNCE_HALF - 1);
   localparam logic [TRANS_CNT_W-1:0]  EXTRA   = TRANS_CNT_W'(2 * BOUNCE_GLITCHES);

   logic                    active_q;
   logic                    line_q;
   logic                    finished_q;
   logic [BOUNCE_CNT_W-1:0] bcnt_q;
   logic [TRANS_CNT_W-1:0]  tcnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q   <= 1'b0;
         line_q     <= 1'b0;
         finished_q <= 1'b0;
         bcnt_q     <= '0;
         tcnt_q     <= '0;
      end else begin
         finished_q <= 1'b0;
         if (clear) begin
            active_q <= 1'b0;
            line_q   <= 1'b0;
            bcnt_q   <= '0;
            tcnt_q   <= '0;
         end else if (start) begin
            // First transition lands on the target; the glitches then toggle
            // an even number of times so the line settles back on it.
            line_q     <= target_level;
            bcnt_q     <= HALF_M1;
            tcnt_q     <= EXTRA;
            active_q   <= (EXTRA != '0);
            finished_q <= (EXTRA == '0);
         end else if (active_q) begin
            if (bcnt_q != '0) begin
               bcnt_q <= bcnt_q - 1'b1;
            end else begin
               line_q <= ~line_q;
               bcnt_q <= HALF_M1;
               tcnt_q <= tcnt_q - 1'b1;
               if (tcnt_q == TRANS_CNT_W'(1)) begin
                  active_q   <= 1'b0;
                  finished_q <= 1'b1;
               end
            end
         end
      end
   end

   assign line     = line_q;
   assign finished = finished_q;

endmodule

`default_nettype wire

// File: rtl/touch_pad_emulator.sv
// ============================================================================
// Module : touch_pad_emulator
// Brief  : Emulates a bouncing momentary or latching touch pad on request.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module touch_pad_emulator
   import touch_pkg::*;
#(
   parameter int BOUNCE_HALF     = DEF_BOUNCE_HALF,
   parameter int BOUNCE_GLITCHES = DEF_BOUNCE_GLITCHES,
   parameter int HOLD_W          = DEF_HOLD_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              press_req,
   input  logic              toggle_mode,
   input  logic [HOLD_W-1:0] hold_len,
   input  logic              abort,
   output logic              touch_signal,
   output logic              busy,
   output logic              done
);

   touch_state_e      state_q;
   logic              toggle_q;
   logic [HOLD_W-1:0] hold_len_q;
   logic [HOLD_W-1:0] hold_q;
   logic              busy_q;
   logic              done_q;

   logic              bounce_start;
   logic              bounce_target;
   logic              bounce_line;
   logic              bounce_finished;
   logic              hold_short;

   // A hold of 0 or 1 starts the down edge straight from the up-edge finish.
   assign hold_short = (hold_len_q <= HOLD_W'(1));

   always_comb begin
      bounce_start  = 1'b0;
      bounce_target = 1'b1;
      if (!abort) begin
         case (state_q)
            IDLE: begin
               if (press_req) begin
                  bounce_start  = 1'b1;
                  bounce_target = !((toggle_mode == MODE_TOGGLE) && bounce_line);
               end
            end
            EDGE_UP: begin
               if (bounce_finished && (toggle_q == MODE_MOMENTARY) && hold_short) begin
                  bounce_start  = 1'b1;
                  bounce_target = 1'b0;
               end
            end
            HELD: begin
               if (hold_q == '0) begin
                  bounce_start  = 1'b1;
                  bounce_target = 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         toggle_q   <= 1'b0;
         hold_len_q <= '0;
         hold_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            hold_q  <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (press_req) begin
                     toggle_q   <= toggle_mode;
                     hold_len_q <= hold_len;
                     busy_q     <= 1'b1;
                     if ((toggle_mode == MODE_TOGGLE) && bounce_line)
                        state_q <= EDGE_DOWN;
                     else
                        state_q <= EDGE_UP;
                  end
               end
               EDGE_UP: begin
                  if (bounce_finished) begin
                     if (toggle_q == MODE_TOGGLE) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                     end else if (hold_short) begin
                        state_q <= EDGE_DOWN;
                     end else begin
                        // The finish cycle is the first plateau cycle, and the
                        // last HELD cycle launches the down edge.
                        hold_q  <= hold_len_q - HOLD_W'(2);
                        state_q <= HELD;
                     end
                  end
               end
               HELD: begin
                  if (hold_q == '0)
                     state_q <= EDGE_DOWN;
                  else
                     hold_q <= hold_q - 1'b1;
               end
               EDGE_DOWN: begin
                  if (bounce_finished) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   touch_bounce_gen #(
      .BOUNCE_HALF     (BOUNCE_HALF),
      .BOUNCE_GLITCHES (BOUNCE_GLITCHES)
   ) u_bounce (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (abort),
      .start        (bounce_start),
      .target_level (bounce_target),
      .line         (bounce_line),
      .finished     (bounce_finished)
   );

   assign touch_signal = bounce_line;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_touch_pad_emulator.sv
// ============================================================================
// Module : tb_touch_pad_emulator
// Brief  : Scoreboard bench: two emulator configurations (clean edge and
//          bouncing edge) driven in parallel with directed presses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_touch_pad_emulator;

   localparam int GA = 0;
   localparam int HA = 1;
   localparam int GB = 2;
   localparam int HB = 4;

   typedef struct {
      bit is_done;
      int cyc;
      bit lvl;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        press_req;
   logic        toggle_mode;
   logic [15:0] hold_len;
   logic        abort;
   logic        tsA, bA, dA, tsB, bB, dB;

   int  cyc = 0;
   int  errors = 0;
   int  checks = 0;
   ev_t q0[$];
   ev_t q1[$];
   int  bfrom[2] = '{0, 0};
   int  bto[2]   = '{-1, -1};
   bit  prev_ts[2] = '{1'b0, 1'b0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   touch_pad_emulator #(.BOUNCE_HALF(HA), .BOUNCE_GLITCHES(GA), .HOLD_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .press_req(press_req), .toggle_mode(toggle_mode),
      .hold_len(hold_len), .abort(abort), .touch_signal(tsA), .busy(bA), .done(dA));

   touch_pad_emulator #(.BOUNCE_HALF(HB), .BOUNCE_GLITCHES(GB), .HOLD_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .press_req(press_req), .toggle_mode(toggle_mode),
      .hold_len(hold_len), .abort(abort), .touch_signal(tsB), .busy(bB), .done(dB));

   task automatic chk(string name, int got, int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic int g_of(int c);
      return (c == 0) ? GA : GB;
   endfunction

   function automatic int h_of(int c);
      return (c == 0) ? HA : HB;
   endfunction

   task automatic push(int c, bit d, int cy, bit l);
      ev_t e;
      e.is_done = d;
      e.cyc     = cy;
      e.lvl     = l;
      if (c == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic exp_edge(int c, int first, bit target, output int last);
      for (int k = 0; k <= 2 * g_of(c); k++)
         push(c, 1'b0, first + k * h_of(c), (k % 2 == 0) ? target : !target);
      last = first + 2 * g_of(c) * h_of(c);
   endtask

   task automatic exp_momentary(int n, int hold);
      int u, f;
      for (int c = 0; c < 2; c++) begin
         exp_edge(c, n + 1, 1'b1, u);
         exp_edge(c, u + ((hold < 1) ? 1 : hold), 1'b0, f);
         push(c, 1'b1, f + 1, 1'b1);
         bfrom[c] = n + 1;
         bto[c]   = f;
      end
   endtask

   task automatic exp_toggle(int n, bit target);
      int f;
      for (int c = 0; c < 2; c++) begin
         exp_edge(c, n + 1, target, f);
         push(c, 1'b1, f + 1, 1'b1);
         bfrom[c] = n + 1;
         bto[c]   = f;
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   task automatic ev_chk(int c, bit d, bit l);
      ev_t e;
      int  have;
      have = (c == 0) ? q0.size() : q1.size();
      chk($sformatf("dut%0d event expected", c), int'(have != 0), 1);
      if (have != 0) begin
         e = (c == 0) ? q0.pop_front() : q1.pop_front();
         chk($sformatf("dut%0d event kind", c), int'(d), int'(e.is_done));
         chk($sformatf("dut%0d event cycle", c), cyc, e.cyc);
         chk($sformatf("dut%0d event level", c), int'(l), int'(e.lvl));
      end
   endtask

   task automatic mon_one(int c, logic ts, logic b, logic d);
      if (ts !== prev_ts[c]) ev_chk(c, 1'b0, ts);
      if (d === 1'b1) ev_chk(c, 1'b1, 1'b1);
      chk($sformatf("dut%0d busy", c), int'(b), int'(cyc >= bfrom[c] && cyc <= bto[c]));
      prev_ts[c] = ts;
   endtask

   always @(negedge clk) begin
      mon_one(0, tsA, bA, dA);
      mon_one(1, tsB, bB, dB);
   end

   // ---------------- stimulus ----------------
   task automatic wait_cyc(int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic start_press(bit tog, int hold, output int n);
      @(negedge clk);
      press_req   = 1'b1;
      toggle_mode = tog;
      hold_len    = 16'(hold);
      n           = cyc;
   endtask

   task automatic end_press();
      @(negedge clk);
      press_req = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      @(negedge clk);
      while ((bA || bB || q0.size() != 0 || q1.size() != 0) && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("sequence completes in budget", int'(k < 300), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_outs(string tag, bit ta, bit ba, bit tb, bit bb);
      chk({tag, " touch A"}, int'(tsA), int'(ta));
      chk({tag, " busy A"},  int'(bA),  int'(ba));
      chk({tag, " touch B"}, int'(tsB), int'(tb));
      chk({tag, " busy B"},  int'(bB),  int'(bb));
   endtask

   initial begin
      int n, u;
      rst_n = 1'b1; press_req = 1'b0; toggle_mode = 1'b0; hold_len = '0; abort = 1'b0;
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset done A", int'(dA), 0);
      chk("reset done B", int'(dB), 0);
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(4);

      // momentary, hold 10, press in cycle 5
      start_press(1'b0, 10, n);
      exp_momentary(n, 10);
      end_press();
      wait_idle();

      // momentary, hold 20; then hold 0 (treated as 1)
      start_press(1'b0, 20, n);
      exp_momentary(n, 20);
      end_press();
      wait_idle();
      start_press(1'b0, 0, n);
      exp_momentary(n, 0);
      end_press();
      wait_idle();

      // toggle mode: two presses with an idle gap
      start_press(1'b1, 0, n);
      exp_toggle(n, 1'b1);
      end_press();
      wait_idle();
      repeat (5) @(negedge clk);
      #1 chk_outs("toggle latched", 1'b1, 1'b0, 1'b1, 1'b0);
      start_press(1'b1, 0, n);
      exp_toggle(n, 1'b0);
      end_press();
      wait_idle();
      #1 chk_outs("toggle released", 1'b0, 1'b0, 1'b0, 1'b0);

      // press held 3 cycles, plus a repeat while busy
      start_press(1'b0, 10, n);
      exp_momentary(n, 10);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      press_req = 1'b0;
      wait_cyc(n + 6);
      press_req = 1'b1;
      @(negedge clk);
      press_req = 1'b0;
      wait_idle();

      // abort during HELD, alone and then together with a press
      for (int rep = 0; rep < 2; rep++) begin
         start_press(1'b0, 30, n);
         for (int c = 0; c < 2; c++) begin
            exp_edge(c, n + 1, 1'b1, u);
            push(c, 1'b0, n + 21, 1'b0);
            bfrom[c] = n + 1;
            bto[c]   = n + 20;
         end
         end_press();
         wait_cyc(n + 20);
         abort     = 1'b1;
         press_req = (rep == 1);
         @(negedge clk);
         abort     = 1'b0;
         press_req = 1'b0;
         #1 chk_outs("after abort", 1'b0, 1'b0, 1'b0, 1'b0);
         wait_idle();
      end

      // abort and press together while idle: press dropped
      @(negedge clk);
      abort = 1'b1; press_req = 1'b1; toggle_mode = 1'b0; hold_len = 16'd5;
      @(negedge clk);
      abort = 1'b0; press_req = 1'b0;
      #1 chk_outs("abort beats press", 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);

      // reset mid-sequence, then a fresh press
      start_press(1'b0, 15, n);
      push(0, 1'b0, n + 1, 1'b1);
      push(1, 1'b0, n + 1, 1'b1);
      push(1, 1'b0, n + 5, 1'b0);
      push(1, 1'b0, n + 9, 1'b1);
      for (int c = 0; c < 2; c++) begin
         push(c, 1'b0, n + 11, 1'b0);
         bfrom[c] = n + 1;
         bto[c]   = n + 10;
      end
      end_press();
      wait_cyc(n + 10);
      #2 rst_n = 1'b0;
      #1 chk_outs("async reset", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("async reset done A", int'(dA), 0);
      chk("async reset done B", int'(dB), 0);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      start_press(1'b0, 3, n);
      exp_momentary(n, 3);
      end_press();
      wait_idle();

      chk("dut0 leftover events", q0.size(), 0);
      chk("dut1 leftover events", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
